// File: rtl/sdram_burst_sched_if.sv
// Command handshake between the burst scheduler and the SDRAM engine.
// The scheduler is the master; the engine acks and signals completion.
interface sdram_burst_sched_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10
);
    logic              cmd_req;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ack;
    logic              cmd_done;

    modport master (
        output cmd_req, cmd_wr, cmd_addr, cmd_len,
        input  cmd_ack, cmd_done
    );

    modport slave (
        input  cmd_req, cmd_wr, cmd_addr, cmd_len,
        output cmd_ack, cmd_done
    );
endinterface

// File: rtl/sdram_burst_sched.sv
// Picks the next full-page burst between write and read FIFOs and
// issues one command at a time with wrapping per-port region pointers.
module sdram_burst_sched #(
    parameter int ADDR_W        = 24,
    parameter int LEN_W         = 10,
    parameter int LVL_W         = 11,
    parameter int RD_FIFO_DEPTH = 1024
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              sdram_read_valid,
    input  logic [ADDR_W-1:0] wr_min_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_min_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [LVL_W-1:0]  wr_fifo_used,
    input  logic [LVL_W-1:0]  rd_fifo_used,
    sdram_burst_sched_if.master cmd,
    output logic              sched_busy
);
    localparam int AW1 = ADDR_W + 1;
    localparam int CW  = LVL_W + 1;

    typedef enum logic [1:0] {
        WAIT_INIT,
        IDLE,
        REQ,
        BUSY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              last_wr;
    logic              kill;
    logic              req_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              busy_q;

    logic              wr_ok;
    logic              rd_ok;
    logic              give_wr;
    logic              give_rd;
    logic              fin;
    logic              hit;
    logic [CW-1:0]     rd_space;

    function automatic logic [LEN_W-1:0] trunc(
        input logic [ADDR_W-1:0] p,
        input logic [ADDR_W-1:0] mx,
        input logic [LEN_W-1:0]  l
    );
        logic [ADDR_W:0] room;
        room = {1'b0, mx} - {1'b0, p};
        return (room < AW1'(l)) ? LEN_W'(room) : l;
    endfunction

    function automatic logic [ADDR_W-1:0] adv(
        input logic [ADDR_W-1:0] p,
        input logic [ADDR_W-1:0] mn,
        input logic [ADDR_W-1:0] mx,
        input logic [LEN_W-1:0]  l
    );
        logic [ADDR_W:0] nx;
        nx = {1'b0, p} + AW1'(l);
        return (nx >= {1'b0, mx}) ? mn : nx[ADDR_W-1:0];
    endfunction

    always_comb begin
        rd_space = CW'(RD_FIFO_DEPTH) - CW'(rd_fifo_used);
        wr_ok    = (wr_len != '0)
                && (CW'(wr_fifo_used) >= CW'(wr_len));
        rd_ok    = sdram_read_valid && (rd_len != '0)
                && (rd_space >= CW'(rd_len));
        give_wr  = wr_ok && (!rd_ok || !last_wr);
        give_rd  = rd_ok && (!wr_ok || last_wr);
        fin      = ((state == REQ) && cmd.cmd_ack && cmd.cmd_done)
                || ((state == BUSY) && cmd.cmd_done);
        hit      = ((state == REQ) || (state == BUSY))
                && (wr_q ? wr_load : rd_load);
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_INIT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            last_wr <= 1'b0;
            kill    <= 1'b0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                WAIT_INIT: begin
                    wr_ptr <= wr_min_addr;
                    rd_ptr <= rd_min_addr;
                    if (sdram_init_done) state <= IDLE;
                end
                IDLE: begin
                    if (!sdram_init_done) begin
                        state <= WAIT_INIT;
                    end else if (give_wr || give_rd) begin
                        state  <= REQ;
                        req_q  <= 1'b1;
                        busy_q <= 1'b1;
                        kill   <= 1'b0;
                        wr_q   <= give_wr;
                        addr_q <= give_wr ? wr_ptr : rd_ptr;
                        len_q  <= give_wr
                            ? trunc(wr_ptr, wr_max_addr, wr_len)
                            : trunc(rd_ptr, rd_max_addr, rd_len);
                    end
                end
                REQ: begin
                    if (cmd.cmd_ack) begin
                        req_q <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: ;
            endcase

            if (hit) kill <= 1'b1;

            // A load seen during this burst voids its pointer advance.
            if (fin) begin
                state   <= IDLE;
                busy_q  <= 1'b0;
                last_wr <= wr_q;
                if (!kill && !hit) begin
                    if (wr_q)
                        wr_ptr <= adv(wr_ptr, wr_min_addr,
                                      wr_max_addr, len_q);
                    else
                        rd_ptr <= adv(rd_ptr, rd_min_addr,
                                      rd_max_addr, len_q);
                end
            end

            if (wr_load) wr_ptr <= wr_min_addr;
            if (rd_load) rd_ptr <= rd_min_addr;
        end
    end

    assign cmd.cmd_req  = req_q;
    assign cmd.cmd_wr   = wr_q;
    assign cmd.cmd_addr = addr_q;
    assign cmd.cmd_len  = len_q;
    assign sched_busy   = busy_q;
endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed bench for sdram_burst_sched with a hand-driven engine.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sdram_burst_sched;
    logic        ref_clk;
    logic        rst_n;
    logic        init_done;
    logic        read_valid;
    logic [23:0] wr_min, wr_max, rd_min, rd_max;
    logic [9:0]  wr_len, rd_len;
    logic        wr_load, rd_load;
    logic [10:0] wr_used, rd_used;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    sdram_burst_sched_if #(.ADDR_W(24), .LEN_W(10)) cmd ();

    sdram_burst_sched #(
        .ADDR_W(24), .LEN_W(10), .LVL_W(11),
        .RD_FIFO_DEPTH(1024)
    ) dut (
        .ref_clk          (ref_clk),
        .rst_n            (rst_n),
        .sdram_init_done  (init_done),
        .sdram_read_valid (read_valid),
        .wr_min_addr      (wr_min),
        .wr_max_addr      (wr_max),
        .rd_min_addr      (rd_min),
        .rd_max_addr      (rd_max),
        .wr_len           (wr_len),
        .rd_len           (rd_len),
        .wr_load          (wr_load),
        .rd_load          (rd_load),
        .wr_fifo_used     (wr_used),
        .rd_fifo_used     (rd_used),
        .cmd              (cmd),
        .sched_busy       (busy)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (cmd.cmd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge ref_clk);
        end
    endtask

    task automatic quiet(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge ref_clk);
            if (cmd.cmd_req === 1'b1) n++;
        end
    endtask

    task automatic serve(input string tag, input bit same);
        cmd.cmd_ack  = 1'b1;
        cmd.cmd_done = same;
        @(negedge ref_clk);
        cmd.cmd_ack  = 1'b0;
        cmd.cmd_done = 1'b0;
        if (!same) begin
            check({tag, "_req_low"}, 32'(cmd.cmd_req), 0);
            check({tag, "_busy"}, 32'(busy), 1);
            cmd.cmd_done = 1'b1;
            @(negedge ref_clk);
            cmd.cmd_done = 1'b0;
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic expect_cmd(
        input string       tag,
        input bit          wr,
        input logic [23:0] addr,
        input logic [9:0]  len,
        input bit          same,
        input int          budget
    );
        bit ok;
        wait_req(budget, ok);
        check({tag, "_req"}, 32'(ok), 1);
        if (ok) begin
            check({tag, "_wr"}, 32'(cmd.cmd_wr), 32'(wr));
            check({tag, "_addr"}, 32'(cmd.cmd_addr), 32'(addr));
            check({tag, "_len"}, 32'(cmd.cmd_len), 32'(len));
            serve(tag, same);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        cmd.cmd_ack  = 1'b0;
        cmd.cmd_done = 1'b0;
        @(negedge ref_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  n;
        bit  ok;
        rst_n        = 1'b0;
        init_done    = 1'b0;
        read_valid   = 1'b0;
        wr_min       = 24'h0;
        wr_max       = 24'h10000;
        rd_min       = 24'h0;
        rd_max       = 24'h10000;
        wr_len       = 10'd256;
        rd_len       = 10'd0;
        wr_load      = 1'b0;
        rd_load      = 1'b0;
        wr_used      = 11'd300;
        rd_used      = 11'd0;
        cmd.cmd_ack  = 1'b0;
        cmd.cmd_done = 1'b0;

        @(negedge ref_clk);
        check("rst_req", 32'(cmd.cmd_req), 0);
        check("rst_wr", 32'(cmd.cmd_wr), 0);
        check("rst_addr", 32'(cmd.cmd_addr), 0);
        check("rst_len", 32'(cmd.cmd_len), 0);
        check("rst_busy", 32'(busy), 0);

        // init gating
        rst_n = 1'b1;
        quiet(20, n);
        check("init_gate", 32'(n), 0);
        init_done = 1'b1;
        expect_cmd("init", 1'b1, 24'h0, 10'd256, 1'b0, 2);
        wr_used = 11'd0;

        // round robin, fresh last_wr
        rd_len     = 10'd256;
        read_valid = 1'b1;
        wr_used    = 11'd300;
        do_reset();
        expect_cmd("rr0", 1'b1, 24'h000, 10'd256, 1'b0, 4);
        expect_cmd("rr1", 1'b0, 24'h000, 10'd256, 1'b0, 4);
        expect_cmd("rr2", 1'b1, 24'h100, 10'd256, 1'b0, 4);
        expect_cmd("rr3", 1'b0, 24'h100, 10'd256, 1'b0, 4);
        wr_used    = 11'd0;
        read_valid = 1'b0;

        // wrap on an exact multiple
        wr_max  = 24'h300;
        wr_used = 11'd300;
        do_reset();
        expect_cmd("wa0", 1'b1, 24'h000, 10'd256, 1'b0, 4);
        expect_cmd("wa1", 1'b1, 24'h100, 10'd256, 1'b0, 4);
        expect_cmd("wa2", 1'b1, 24'h200, 10'd256, 1'b0, 4);
        expect_cmd("wa3", 1'b1, 24'h000, 10'd256, 1'b0, 4);

        // truncation at region end
        wr_max = 24'h280;
        do_reset();
        expect_cmd("tr0", 1'b1, 24'h000, 10'd256, 1'b0, 4);
        expect_cmd("tr1", 1'b1, 24'h100, 10'd256, 1'b0, 4);
        expect_cmd("tr2", 1'b1, 24'h200, 10'h080, 1'b0, 4);
        expect_cmd("tr3", 1'b1, 24'h000, 10'd256, 1'b0, 4);
        wr_used = 11'd0;
        wr_max  = 24'h10000;

        // read throttle on free space
        read_valid = 1'b1;
        rd_used    = 11'd769;
        do_reset();
        quiet(10, n);
        check("rd_full", 32'(n), 0);
        rd_used = 11'd768;
        expect_cmd("rd_room", 1'b0, 24'h0, 10'd256, 1'b0, 4);
        read_valid = 1'b0;
        rd_used    = 11'd0;
        quiet(10, n);
        check("rd_off", 32'(n), 0);

        // ack+done together, then load during BUSY
        wr_used = 11'd300;
        do_reset();
        expect_cmd("same", 1'b1, 24'h000, 10'd256, 1'b1, 4);
        wait_req(4, ok);
        check("ld_req", 32'(ok), 1);
        check("ld_addr", 32'(cmd.cmd_addr), 32'h100);
        cmd.cmd_ack = 1'b1;
        @(negedge ref_clk);
        cmd.cmd_ack = 1'b0;
        wr_load     = 1'b1;
        check("ld_busy", 32'(busy), 1);
        @(negedge ref_clk);
        wr_load      = 1'b0;
        check("ld_still", 32'(busy), 1);
        cmd.cmd_done = 1'b1;
        @(negedge ref_clk);
        cmd.cmd_done = 1'b0;
        expect_cmd("ld_next", 1'b1, 24'h000, 10'd256, 1'b0, 4);

        // async reset while BUSY
        wr_min = 24'h400;
        do_reset();
        expect_cmd("ar0", 1'b1, 24'h400, 10'd256, 1'b0, 4);
        wait_req(4, ok);
        check("ar1_req", 32'(ok), 1);
        check("ar1_addr", 32'(cmd.cmd_addr), 32'h500);
        cmd.cmd_ack = 1'b1;
        @(negedge ref_clk);
        cmd.cmd_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_req", 32'(cmd.cmd_req), 0);
        check("ar_wr", 32'(cmd.cmd_wr), 0);
        check("ar_addr", 32'(cmd.cmd_addr), 0);
        check("ar_len", 32'(cmd.cmd_len), 0);
        check("ar_busy", 32'(busy), 0);
        @(negedge ref_clk);
        rst_n = 1'b1;
        expect_cmd("ar_rst", 1'b1, 24'h400, 10'd256, 1'b0, 4);
        wr_used = 11'd0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
